// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   arb_state_t : transaction state machine encoding (IDLE, ISSUE, WAIT, DONE)
//   ARB_FIXED   : RR_MODE value selecting fixed priority (port 0 highest)
//   ARB_RR      : RR_MODE value selecting round-robin arbitration
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Rotated priority encoder used to pick the next owner of the memory port.
// The search starts at ptr (round robin) or at 0 (fixed priority) and wraps.
//   mask    in  NUM_PORTS  eligible requesters
//   ptr     in  IDX_W      round-robin start index (ignored in fixed mode)
//   rr_mode in  1          1 = start the search at ptr, 0 = start at port 0
//   valid   out 1          at least one port is eligible
//   winner  out IDX_W      index of the selected port
module mem_arb_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] mask,
  input  logic [IDX_W-1:0]     ptr,
  input  logic                 rr_mode,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  logic [2*NUM_PORTS-1:0] doubled;
  logic [NUM_PORTS-1:0]   rotated;
  logic [IDX_W-1:0]       base;
  logic [IDX_W:0]         sum;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    base    = rr_mode ? ptr : '0;
    // Bit i of rotated is port (base + i) mod NUM_PORTS, since base < NUM_PORTS.
    doubled = {mask, mask} >> base;
    rotated = doubled[NUM_PORTS-1:0];
    valid   = |mask;
    winner  = '0;
    sum     = '0;
    // Scan downward so the lowest rotated offset is the last one written.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        sum    = {1'b0, base} + (IDX_W+1)'(i);
        winner = (sum >= (IDX_W+1)'(NUM_PORTS)) ? IDX_W'(sum - (IDX_W+1)'(NUM_PORTS))
                                                 : IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter sharing one memory controller port, one transaction at a time.
// Typical hookup: init on port 0, CPU on port 1, lock_en = ~cpu_enable and
// lock_sel = 0 reproduce the old static init/CPU select.
//   clk, rst              clock and synchronous active-high reset
//   port_addr/data_in     per-port address and write data (port i at slice i)
//   port_r_en/port_w_en   per-port level requests; both high means write
//   port_cplt             one-cycle completion pulse to the owning port
//   port_rd_data          last read data, shared by all ports
//   lock_en/lock_sel      restrict eligibility to a single port
//   mem_*                 memory controller command/response interface
//   busy                  high whenever a transaction is in flight
//   grant_idx             current or most recent owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int RR_MODE    = ARB_FIXED,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_in,
  input  logic [NUM_PORTS-1:0]            port_r_en,
  input  logic [NUM_PORTS-1:0]            port_w_en,
  output logic [NUM_PORTS-1:0]            port_cplt,
  output logic [DATA_WIDTH-1:0]           port_rd_data,
  input  logic                            lock_en,
  input  logic [IDX_W-1:0]                lock_sel,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_data_in,
  output logic                            mem_r_en,
  output logic                            mem_w_en,
  input  logic                            mem_rdy,
  input  logic                            mem_cplt,
  input  logic [DATA_WIDTH-1:0]           mem_data_out,
  output logic                            busy,
  output logic [IDX_W-1:0]                grant_idx
);

  localparam logic RR_EN = (RR_MODE == ARB_RR);

  arb_state_t state, next_state;

  logic [IDX_W-1:0]      rr_ptr;
  logic                  op_write;
  logic [NUM_PORTS-1:0]  req, eligible, lock_mask;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_write;

  assign req       = port_r_en | port_w_en;
  assign lock_mask = NUM_PORTS'(1) << lock_sel;
  assign eligible  = lock_en ? (req & lock_mask) : req;

  mem_arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .mask    (eligible),
    .ptr     (rr_ptr),
    .rr_mode (RR_EN),
    .valid   (pick_valid),
    .winner  (pick_idx)
  );

  // Mux out the winner's command; a write takes precedence over a read.
  always_comb begin
    win_addr  = '0;
    win_data  = '0;
    win_write = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        win_addr  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_data  = port_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        win_write = port_w_en[i];
      end
    end
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid && mem_rdy) begin
          grant      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (mem_cplt) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: the data registers are reset as well as the control bits because
  // every output, including address and read data, must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      op_write     <= 1'b0;
      grant_idx    <= '0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      mem_r_en     <= 1'b0;
      mem_w_en     <= 1'b0;
      port_cplt    <= '0;
      port_rd_data <= '0;
      busy         <= 1'b0;
    end else begin
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      port_cplt <= '0;
      busy      <= (next_state != IDLE);
      if (grant) begin
        grant_idx   <= pick_idx;
        op_write    <= win_write;
        mem_addr    <= win_addr;
        mem_data_in <= win_data;
        mem_w_en    <= win_write;
        mem_r_en    <= ~win_write;
      end
      // Completion outside WAIT is ignored; port_rd_data only follows reads.
      if (state == WAIT && mem_cplt) begin
        port_cplt <= NUM_PORTS'(1) << grant_idx;
        if (!op_write) port_rd_data <= mem_data_out;
      end
      if (RR_EN && state == DONE) begin
        rr_ptr <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a 2-port fixed-priority instance (dut_a)
// and a 3-port round-robin instance (dut_b) share clock and reset. The bench
// plays the memory controller by hand, pulsing mem_cplt a chosen number of
// cycles after the command.
module tb_mem_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dut_a: NUM_PORTS=2, fixed priority
  logic [2*AW-1:0] a_port_addr;
  logic [2*DW-1:0] a_port_data_in;
  logic [1:0]      a_port_r_en, a_port_w_en, a_port_cplt;
  logic [DW-1:0]   a_port_rd_data;
  logic            a_lock_en;
  logic [0:0]      a_lock_sel;
  logic [AW-1:0]   a_mem_addr;
  logic [DW-1:0]   a_mem_data_in, a_mem_data_out;
  logic            a_mem_r_en, a_mem_w_en, a_mem_rdy, a_mem_cplt, a_busy;
  logic [0:0]      a_grant_idx;

  // dut_b: NUM_PORTS=3, round robin
  logic [3*AW-1:0] b_port_addr;
  logic [3*DW-1:0] b_port_data_in;
  logic [2:0]      b_port_r_en, b_port_w_en, b_port_cplt;
  logic [DW-1:0]   b_port_rd_data;
  logic            b_lock_en;
  logic [1:0]      b_lock_sel;
  logic [AW-1:0]   b_mem_addr;
  logic [DW-1:0]   b_mem_data_in, b_mem_data_out;
  logic            b_mem_r_en, b_mem_w_en, b_mem_rdy, b_mem_cplt, b_busy;
  logic [1:0]      b_grant_idx;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) dut_a (
    .clk(clk), .rst(rst),
    .port_addr(a_port_addr), .port_data_in(a_port_data_in),
    .port_r_en(a_port_r_en), .port_w_en(a_port_w_en),
    .port_cplt(a_port_cplt), .port_rd_data(a_port_rd_data),
    .lock_en(a_lock_en), .lock_sel(a_lock_sel),
    .mem_addr(a_mem_addr), .mem_data_in(a_mem_data_in),
    .mem_r_en(a_mem_r_en), .mem_w_en(a_mem_w_en),
    .mem_rdy(a_mem_rdy), .mem_cplt(a_mem_cplt), .mem_data_out(a_mem_data_out),
    .busy(a_busy), .grant_idx(a_grant_idx)
  );

  mem_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) dut_b (
    .clk(clk), .rst(rst),
    .port_addr(b_port_addr), .port_data_in(b_port_data_in),
    .port_r_en(b_port_r_en), .port_w_en(b_port_w_en),
    .port_cplt(b_port_cplt), .port_rd_data(b_port_rd_data),
    .lock_en(b_lock_en), .lock_sel(b_lock_sel),
    .mem_addr(b_mem_addr), .mem_data_in(b_mem_data_in),
    .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en),
    .mem_rdy(b_mem_rdy), .mem_cplt(b_mem_cplt), .mem_data_out(b_mem_data_out),
    .busy(b_busy), .grant_idx(b_grant_idx)
  );

  // Observation point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until a memory command pulse is visible (the ISSUE cycle).
  task automatic wait_issue_a(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        tick();
        if (a_mem_r_en || a_mem_w_en) found = 1'b1;
      end
    end
  endtask

  task automatic wait_issue_b(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        tick();
        if (b_mem_r_en || b_mem_w_en) found = 1'b1;
      end
    end
  endtask

  // Called in the ISSUE cycle: raise mem_cplt lat cycles after ISSUE, then
  // return observing the DONE cycle.
  task automatic complete_a(input int lat, input logic [DW-1:0] d);
    for (int i = 0; i < lat; i++) tick();
    a_mem_cplt = 1'b1; a_mem_data_out = d;
    tick();
    a_mem_cplt = 1'b0; a_mem_data_out = '0;
  endtask

  task automatic complete_b(input int lat, input logic [DW-1:0] d);
    for (int i = 0; i < lat; i++) tick();
    b_mem_cplt = 1'b1; b_mem_data_out = d;
    tick();
    b_mem_cplt = 1'b0; b_mem_data_out = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_port_addr = '0; a_port_data_in = '0; a_port_r_en = '0; a_port_w_en = '0;
    a_lock_en = 1'b0; a_lock_sel = '0; a_mem_rdy = 1'b1; a_mem_cplt = 1'b0; a_mem_data_out = '0;
    b_port_addr = '0; b_port_data_in = '0; b_port_r_en = '0; b_port_w_en = '0;
    b_lock_en = 1'b0; b_lock_sel = '0; b_mem_rdy = 1'b1; b_mem_cplt = 1'b0; b_mem_data_out = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({a_mem_addr, a_mem_data_in, a_mem_r_en, a_mem_w_en, a_port_cplt,
         a_port_rd_data, a_busy, a_grant_idx} !== '0) begin
      failures++;
      $display("FAIL reset_a outputs got addr=%h wd=%h r=%b w=%b cplt=%b rd=%h busy=%b gi=%h want all 0",
               a_mem_addr, a_mem_data_in, a_mem_r_en, a_mem_w_en, a_port_cplt,
               a_port_rd_data, a_busy, a_grant_idx);
    end
    checks++;
    if ({b_mem_addr, b_mem_data_in, b_mem_r_en, b_mem_w_en, b_port_cplt,
         b_port_rd_data, b_busy, b_grant_idx} !== '0) begin
      failures++;
      $display("FAIL reset_b outputs not all zero (busy=%b gi=%h cplt=%b)", b_busy, b_grant_idx, b_port_cplt);
    end
  endtask

  task automatic test_single_read();
    bit found;
    a_port_addr[AW +: AW] = 24'h000123;
    a_port_r_en = 2'b10;
    wait_issue_a(found);
    checks++;
    if (!found) begin failures++; $display("FAIL single_issue timeout"); return; end
    checks++;
    if ({a_mem_r_en, a_mem_w_en} !== 2'b10) begin
      failures++; $display("FAIL single_enables got r=%b w=%b want r=1 w=0", a_mem_r_en, a_mem_w_en);
    end
    checks++;
    if (a_mem_addr !== 24'h000123) begin
      failures++; $display("FAIL single_addr got=%h want=000123", a_mem_addr);
    end
    checks++;
    if (a_grant_idx !== 1'b1 || a_busy !== 1'b1) begin
      failures++; $display("FAIL single_grant got gi=%h busy=%b want gi=1 busy=1", a_grant_idx, a_busy);
    end
    tick();  // WAIT, first cycle
    checks++;
    if ({a_mem_r_en, a_mem_w_en} !== 2'b00 || a_mem_addr !== 24'h000123) begin
      failures++; $display("FAIL single_pulse got r=%b w=%b addr=%h want 0 0 000123", a_mem_r_en, a_mem_w_en, a_mem_addr);
    end
    tick(); tick();  // mem_cplt lands 3 cycles after ISSUE
    a_mem_cplt = 1'b1; a_mem_data_out = 16'hBEEF;
    tick();
    a_mem_cplt = 1'b0; a_mem_data_out = '0;
    a_port_r_en = 2'b00;
    checks++;
    if (a_port_cplt !== 2'b10) begin
      failures++; $display("FAIL single_cplt got=%b want=10", a_port_cplt);
    end
    checks++;
    if (a_port_rd_data !== 16'hBEEF) begin
      failures++; $display("FAIL single_rd_data got=%h want=beef", a_port_rd_data);
    end
    tick();
    checks++;
    if (a_port_cplt !== 2'b00 || a_port_rd_data !== 16'hBEEF || a_busy !== 1'b0) begin
      failures++; $display("FAIL single_after got cplt=%b rd=%h busy=%b want 00 beef 0",
                           a_port_cplt, a_port_rd_data, a_busy);
    end
  endtask

  task automatic test_fixed_priority();
    bit found;
    a_port_addr[0 +: AW]  = 24'h000200;
    a_port_addr[AW +: AW] = 24'h000300;
    a_port_r_en = 2'b11;
    wait_issue_a(found);
    checks++;
    if (!found) begin failures++; $display("FAIL fixed_issue0 timeout"); return; end
    checks++;
    if (a_grant_idx !== 1'b0 || a_mem_addr !== 24'h000200) begin
      failures++; $display("FAIL fixed_first got gi=%h addr=%h want gi=0 addr=000200", a_grant_idx, a_mem_addr);
    end
    complete_a(1, 16'h1111);
    a_port_r_en = 2'b10;
    checks++;
    if (a_port_cplt !== 2'b01 || a_port_rd_data !== 16'h1111) begin
      failures++; $display("FAIL fixed_cplt0 got cplt=%b rd=%h want 01 1111", a_port_cplt, a_port_rd_data);
    end
    wait_issue_a(found);
    checks++;
    if (!found) begin failures++; $display("FAIL fixed_issue1 timeout"); return; end
    checks++;
    if (a_grant_idx !== 1'b1 || a_mem_addr !== 24'h000300) begin
      failures++; $display("FAIL fixed_second got gi=%h addr=%h want gi=1 addr=000300", a_grant_idx, a_mem_addr);
    end
    complete_a(2, 16'h2222);
    a_port_r_en = 2'b00;
    checks++;
    if (a_port_cplt !== 2'b10 || a_port_rd_data !== 16'h2222) begin
      failures++; $display("FAIL fixed_cplt1 got cplt=%b rd=%h want 10 2222", a_port_cplt, a_port_rd_data);
    end
    tick();
  endtask

  task automatic test_lock();
    bit found;
    int pulses;
    a_lock_en = 1'b1; a_lock_sel = 1'b0;
    a_port_addr[AW +: AW] = 24'h000777;
    a_port_r_en = 2'b10;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_mem_r_en || a_mem_w_en || a_busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL lock_blocked got=%0d active cycles want=0", pulses);
    end
    a_port_addr[0 +: AW]    = 24'h000010;
    a_port_data_in[0 +: DW] = 16'h55AA;
    a_port_w_en = 2'b01;
    wait_issue_a(found);
    checks++;
    if (!found) begin failures++; $display("FAIL lock_issue timeout"); return; end
    checks++;
    if ({a_mem_r_en, a_mem_w_en} !== 2'b01 || a_mem_addr !== 24'h000010 || a_mem_data_in !== 16'h55AA) begin
      failures++; $display("FAIL lock_write got r=%b w=%b addr=%h wd=%h want 0 1 000010 55aa",
                           a_mem_r_en, a_mem_w_en, a_mem_addr, a_mem_data_in);
    end
    checks++;
    if (a_grant_idx !== 1'b0) begin
      failures++; $display("FAIL lock_grant got=%h want=0", a_grant_idx);
    end
    complete_a(1, 16'hDEAD);
    a_port_w_en = 2'b00;
    checks++;
    // A write completion must not disturb the last read data.
    if (a_port_cplt !== 2'b01 || a_port_rd_data !== 16'h2222) begin
      failures++; $display("FAIL lock_cplt got cplt=%b rd=%h want 01 2222", a_port_cplt, a_port_rd_data);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_mem_r_en || a_mem_w_en) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL lock_after got=%0d pulses want=0", pulses);
    end
    a_port_r_en = 2'b00;
    a_lock_en = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    bit found;
    int active;
    a_mem_rdy = 1'b0;
    a_port_addr[0 +: AW] = 24'h000ABC;
    a_port_r_en = 2'b01;
    active = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_mem_r_en || a_mem_w_en || a_busy) active++;
    end
    checks++;
    if (active !== 0) begin
      failures++; $display("FAIL stall_idle got=%0d active cycles want=0", active);
    end
    a_mem_rdy = 1'b1;
    tick();
    checks++;
    if (a_mem_r_en !== 1'b1 || a_mem_addr !== 24'h000ABC) begin
      failures++; $display("FAIL stall_release got r=%b addr=%h want 1 000abc", a_mem_r_en, a_mem_addr);
    end
    found = a_mem_r_en;
    if (found) begin
      complete_a(1, 16'h0F0F);
      checks++;
      if (a_port_cplt !== 2'b01 || a_port_rd_data !== 16'h0F0F) begin
        failures++; $display("FAIL stall_cplt got cplt=%b rd=%h want 01 0f0f", a_port_cplt, a_port_rd_data);
      end
    end
    a_port_r_en = 2'b00;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    bit found;
    int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
    b_port_addr[0 +: AW]    = 24'h000100;
    b_port_addr[AW +: AW]   = 24'h000101;
    b_port_addr[2*AW +: AW] = 24'h000102;
    b_port_r_en = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_issue_b(found);
      checks++;
      if (!found) begin
        failures++; $display("FAIL rr_issue%0d timeout", k);
        b_port_r_en = '0;
        return;
      end
      checks++;
      if (b_grant_idx !== 2'(exp_seq[k]) || b_mem_addr !== 24'h000100 + 24'(exp_seq[k])) begin
        failures++; $display("FAIL rr_grant%0d got gi=%0d addr=%h want gi=%0d", k, b_grant_idx, b_mem_addr, exp_seq[k]);
      end
      complete_b(1, 16'hA000 + 16'(k));
      checks++;
      if (b_port_cplt !== 3'(1 << exp_seq[k]) || b_port_rd_data !== 16'hA000 + 16'(k)) begin
        failures++; $display("FAIL rr_cplt%0d got cplt=%b rd=%h want port %0d", k, b_port_cplt, b_port_rd_data, exp_seq[k]);
      end
    end
    b_port_r_en = 3'b000;
    tick(); tick();
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    int stray;
    a_port_addr[AW +: AW] = 24'h000456;
    a_port_r_en = 2'b10;
    wait_issue_a(found);
    checks++;
    if (!found) begin failures++; $display("FAIL midrst_issue timeout"); a_port_r_en = '0; return; end
    tick();  // now in WAIT
    rst = 1'b1;
    a_port_r_en = 2'b00;
    tick();
    rst = 1'b0;
    checks++;
    if ({a_mem_addr, a_mem_data_in, a_mem_r_en, a_mem_w_en, a_port_cplt,
         a_port_rd_data, a_busy, a_grant_idx} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got addr=%h rd=%h busy=%b gi=%h cplt=%b want all 0",
               a_mem_addr, a_port_rd_data, a_busy, a_grant_idx, a_port_cplt);
    end
    a_mem_cplt = 1'b1; a_mem_data_out = 16'h1234;
    tick();
    a_mem_cplt = 1'b0; a_mem_data_out = '0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_port_cplt !== 2'b00 || a_busy !== 1'b0 || a_port_rd_data !== '0) stray++;
      tick();
    end
    checks++;
    if (stray !== 0) begin
      failures++; $display("FAIL midrst_late_cplt got=%0d bad cycles want=0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_lock();
    test_stall();
    test_round_robin();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
